python_spi_master: RTL and testbench
====================================

# python_spi_master

SPI master for the PYTHON300 image-sensor register port. It sits directly downstream of the I2C-to-register bridge. It accepts one register command (9-bit address, write flag, 16-bit data) per valid/ready handshake and serialises it as a single 26-bit PYTHON300 SPI frame. For read commands it returns the 16-bit register value as a one-cycle `m_rvalid` pulse.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `clk` cycles. Legal range 2..255.
- `reset`  in  1  asynchronous, active-high reset
- `clk`  in  1  system clock; all logic is in this domain
- `s_addr`  in  9  sensor register address
- `s_we`  in  1  1 = write, 0 = read
- `s_wdata`  in  16  write data; ignored for reads
- `s_valid`  in  1  command valid; held high until accepted
- `s_ready`  out  1  high only in IDLE; a command is accepted on the edge where `s_valid & s_ready`
- `m_rdata`  out  16  read data; holds its value until the next read completes
- `m_rvalid`  out  1  one-cycle pulse per completed read
- `spi_ss_n`  out  1  sensor chip select, active low
- `spi_sck`  out  1  SPI clock, idles low
- `spi_mosi`  out  1  serial data to the sensor
- `spi_miso`  in  1  serial data from the sensor

## Operation
- Frame layout, MSB first, 26 bits: `addr[8:0]`, then `we`, then `data[15:0]`.
  - For reads, the data bits on MOSI are 0.
  - For reads, MISO is captured during bits 10..25 into `m_rdata[15:0]`, MSB first.
- On accept, `s_addr`, `s_we` and `s_wdata` are latched into a 26-bit shift register. Input changes after accept have no effect.
- State machine:
  - IDLE → SETUP on accept.
  - SETUP → SHIFT after `CLK_DIV` cycles.
  - SHIFT → HOLD after 26 bits.
  - HOLD → GAP after `CLK_DIV` cycles.
  - GAP → IDLE after `CLK_DIV` cycles.
- Signals per state:
  - SETUP: `spi_ss_n`=0, `spi_sck`=0, `spi_mosi`=bit 25.
  - SHIFT, each bit: SCK low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles. The sensor samples MOSI on the SCK rising edge.
  - SHIFT, at the `clk` edge that drives SCK high→low: MISO is sampled into the read shift register, and MOSI advances to the next bit on that same edge.
  - HOLD: SCK=0, `spi_ss_n`=0.
  - GAP: `spi_ss_n`=1. On entry to GAP, a read latches `m_rdata` and pulses `m_rvalid` for exactly one cycle. Writes produce no `m_rvalid`.
- `s_ready` is a combinational decode of IDLE. No commands are queued, and back-to-back frames are always separated by GAP.
- A single internal counter of width ⌈log2(2·`CLK_DIV`)⌉ times the phases, plus a 5-bit bit counter (0..25). Neither counter wraps beyond its terminal value; both reload on each state change.

## Timing
- Reset values: `s_ready`=1 (IDLE), `spi_ss_n`=1, `spi_sck`=0, `spi_mosi`=0, `m_rvalid`=0, `m_rdata`=0.
- Accept at edge N:
  - `spi_ss_n` falls at N.
  - First SCK rise at N+`CLK_DIV`.
  - Last SCK fall at N+`CLK_DIV`+52·`CLK_DIV`.
  - `spi_ss_n` rises at N+54·`CLK_DIV`.
  - `m_rvalid` is high for the cycle following N+54·`CLK_DIV`.
  - `s_ready` returns high at N+55·`CLK_DIV`.
  - Example, `CLK_DIV`=4: SS low for 216 cycles, 220 cycles accept-to-ready.
- The earliest next accept is the same edge on which `s_ready` is first high again.
- Reset asserted mid-frame: all outputs go to their reset values asynchronously. The frame is abandoned, with no `m_rvalid` and no partial `m_rdata` update.
- `s_valid` deasserting without a handshake while not ready is legal and has no effect.

## Test plan
- Reset release with `s_valid`=0: `spi_ss_n`=1, `spi_sck`=0, `s_ready`=1 held for 100 cycles, no SCK edges.
- Write addr=0x1A5, wdata=0xBEEF, `CLK_DIV`=4:
  - Sensor model decodes 26 bits = 1_1010_0101_1_1011111011101111 on SCK rises.
  - Exactly 26 SCK rises, SS low for 216 cycles, no `m_rvalid`.
- Read addr=0x010, sensor model drives 0x5A3C on MISO after falling edges: `m_rdata`=0x5A3C with a single `m_rvalid` pulse, 216 cycles after the SS fall.
- `s_valid` held high with 3 commands queued back-to-back:
  - Each frame starts on the edge where `s_ready` returns high, with a `CLK_DIV`-cycle gap of SS high between frames.
  - Changing `s_wdata` mid-frame does not corrupt the frame in flight.
- Reset pulsed 100 cycles into a read frame:
  - SS rises and SCK drops immediately, with no `m_rvalid`.
  - The next command is a correct full frame.
- `CLK_DIV`=2 and `CLK_DIV`=255: SCK high and low phases are exactly `CLK_DIV` cycles each, and read/write data is correct.

Source files
------------

// File: rtl/python_spi_master.sv
// SPI master for the PYTHON300 register port: one 26-bit frame (addr, we, data)
// per accepted command, with read data returned as a one-cycle m_rvalid pulse.
module python_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        reset,
    input  logic        clk,
    input  logic [8:0]  s_addr,
    input  logic        s_we,
    input  logic [15:0] s_wdata,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] m_rdata,
    output logic        m_rvalid,
    output logic        spi_ss_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] PHASE_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_END   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [4:0]    LAST_BIT  = 5'd25;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_cnt;
    logic [25:0]   sr;
    logic          is_read;

    assign s_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            is_read  <= 1'b0;
            m_rdata  <= '0;
            m_rvalid <= 1'b0;
            spi_ss_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            m_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s_valid) begin
                        state    <= SETUP;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        sr       <= {s_addr, s_we, (s_we ? s_wdata : 16'h0000)};
                        is_read  <= ~s_we;
                        spi_ss_n <= 1'b0;
                        spi_sck  <= 1'b0;
                        spi_mosi <= s_addr[8];
                    end
                end
                SETUP: begin
                    if (cnt == PHASE_END) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                SHIFT: begin
                    // One shared register shifts MOSI out of the top and MISO in at the bottom;
                    // after 26 falls its low 16 bits hold exactly the read data bits 10..25.
                    if (cnt == PHASE_END) begin
                        spi_sck <= 1'b1;
                        cnt     <= cnt + CNT_ONE;
                    end else if (cnt == BIT_END) begin
                        spi_sck <= 1'b0;
                        sr      <= {sr[24:0], spi_miso};
                        cnt     <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            state    <= HOLD;
                            bit_cnt  <= '0;
                            spi_mosi <= 1'b0;
                        end else begin
                            bit_cnt  <= bit_cnt + 5'd1;
                            spi_mosi <= sr[24];
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt == PHASE_END) begin
                        state    <= GAP;
                        cnt      <= '0;
                        spi_ss_n <= 1'b1;
                        if (is_read) begin
                            m_rdata  <= sr[15:0];
                            m_rvalid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                GAP: begin
                    if (cnt == PHASE_END) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_python_spi_master.sv
// Bench for python_spi_master: three instances (CLK_DIV 4, 2, 255) with a sensor
// model decoding MOSI on SCK rises and driving MISO after SCK falls.
module tb_python_spi_master;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  s_addr   [N];
    logic        s_we     [N];
    logic [15:0] s_wdata  [N];
    logic        s_valid  [N];
    logic        s_ready  [N];
    logic [15:0] m_rdata  [N];
    logic        m_rvalid [N];
    logic        spi_ss_n [N];
    logic        spi_sck  [N];
    logic        spi_mosi [N];
    logic        spi_miso [N] = '{default: 1'b0};

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        python_spi_master #(.CLK_DIV(g == 0 ? 4 : (g == 1 ? 2 : 255))) u_dut (
            .reset    (reset),
            .clk      (clk),
            .s_addr   (s_addr[g]),
            .s_we     (s_we[g]),
            .s_wdata  (s_wdata[g]),
            .s_valid  (s_valid[g]),
            .s_ready  (s_ready[g]),
            .m_rdata  (m_rdata[g]),
            .m_rvalid (m_rvalid[g]),
            .spi_ss_n (spi_ss_n[g]),
            .spi_sck  (spi_sck[g]),
            .spi_mosi (spi_mosi[g]),
            .spi_miso (spi_miso[g])
        );
    end

    function automatic int divk(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 255);
    endfunction

    // Sensor model and bus monitor
    int          rises     [N] = '{default: 0};
    int          falls     [N] = '{default: 0};
    int          phase_err [N] = '{default: 0};
    int          rv_cnt    [N] = '{default: 0};
    int          rv_delay  [N] = '{default: 0};
    int          sslow     [N] = '{default: 0};
    int          fall_cyc  [N] = '{default: 0};
    int          rise_cyc  [N] = '{default: 0};
    int          edge_cyc  [N] = '{default: 0};
    int          sck_edges [N] = '{default: 0};
    logic [25:0] mosi_cap  [N] = '{default: 26'h0};
    logic [15:0] sens      [N] = '{default: 16'h0};
    logic        sck_q     [N] = '{default: 1'b0};
    logic        ss_q      [N] = '{default: 1'b1};
    logic [15:0] prev_rd   [N] = '{default: 16'h0};

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (spi_sck[k] !== sck_q[k]) sck_edges[k]++;
            if (spi_ss_n[k] === 1'b0 && ss_q[k] === 1'b1) begin
                rises[k] = 0; falls[k] = 0; phase_err[k] = 0; rv_cnt[k] = 0;
                mosi_cap[k] = '0; fall_cyc[k] = cyc; spi_miso[k] = 1'b0;
            end
            if (spi_ss_n[k] === 1'b1 && ss_q[k] === 1'b0) begin
                sslow[k] = cyc - fall_cyc[k];
                rise_cyc[k] = cyc;
            end
            if (spi_sck[k] === 1'b1 && sck_q[k] === 1'b0) begin
                if (spi_ss_n[k] !== 1'b0) phase_err[k]++;
                if (falls[k] > 0 && (cyc - edge_cyc[k]) != divk(k)) phase_err[k]++;
                rises[k]++;
                mosi_cap[k] = {mosi_cap[k][24:0], spi_mosi[k]};
                edge_cyc[k] = cyc;
            end
            if (spi_sck[k] === 1'b0 && sck_q[k] === 1'b1) begin
                if ((cyc - edge_cyc[k]) != divk(k)) phase_err[k]++;
                edge_cyc[k] = cyc;
                falls[k]++;
                spi_miso[k] = (falls[k] >= 10 && falls[k] <= 25) ? sens[k][25 - falls[k]] : 1'b0;
            end
            if (m_rvalid[k] === 1'b1) begin
                rv_cnt[k]++;
                rv_delay[k] = cyc - fall_cyc[k];
            end
            sck_q[k] = spi_sck[k];
            ss_q[k]  = spi_ss_n[k];
        end
    end

    // Issues one command, scrambles the inputs right after accept, waits for ready.
    task automatic do_cmd(input int k, input logic [8:0] a, input logic we,
                          input logic [15:0] wd, input logic [15:0] sv,
                          output int acc2rdy, output bit tmo);
        int w;
        int acc;
        tmo = 1'b0;
        @(negedge clk);
        s_addr[k] = a; s_we[k] = we; s_wdata[k] = wd; sens[k] = sv; s_valid[k] = 1'b1;
        w = 0;
        while (s_ready[k] !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        acc = cyc;
        s_valid[k] = 1'b0;
        s_addr[k] = 9'($urandom); s_we[k] = ~we; s_wdata[k] = 16'($urandom);
        w = 0;
        @(negedge clk);
        while (s_ready[k] !== 1'b1 && w < 60 * divk(k) + 50) begin @(negedge clk); w++; end
        if (s_ready[k] !== 1'b1) tmo = 1'b1;
        acc2rdy = cyc - acc;
    endtask

    task automatic test_reset();
        int viol;
        int e0 [N];
        reset = 1'b1;
        for (int k = 0; k < N; k++) begin
            s_addr[k] = '0; s_we[k] = 1'b0; s_wdata[k] = '0; s_valid[k] = 1'b0;
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N; k++) e0[k] = sck_edges[k];
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            for (int k = 0; k < N; k++)
                if (spi_ss_n[k] !== 1'b1 || spi_sck[k] !== 1'b0 || s_ready[k] !== 1'b1) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL reset_idle_levels: got %0d bad cycles want 0", viol); end
        for (int k = 0; k < N; k++) begin
            total++;
            if (sck_edges[k] != e0[k]) begin bad++; $display("FAIL reset_sck_edges[%0d]: got %0d want %0d", k, sck_edges[k], e0[k]); end
            total++;
            if (m_rdata[k] !== 16'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %0h want 0", k, m_rdata[k]); end
            total++;
            if (m_rvalid[k] !== 1'b0 || spi_mosi[k] !== 1'b0) begin
                bad++; $display("FAIL reset_rvalid_mosi[%0d]: got %b%b want 00", k, m_rvalid[k], spi_mosi[k]);
            end
        end
    endtask

    task automatic test_write();
        logic [8:0]  a;
        logic [15:0] wd;
        logic [25:0] exp_f;
        int          a2r;
        bit          tmo;
        for (int i = 0; i < 4; i++) begin
            a  = (i == 0) ? 9'h1A5 : 9'($urandom);
            wd = (i == 0) ? 16'hBEEF : 16'($urandom);
            exp_f = {a, 1'b1, wd};
            do_cmd(0, a, 1'b1, wd, 16'($urandom), a2r, tmo);
            total++;
            if (tmo) begin bad++; $display("FAIL wr_timeout: got timeout want ready"); end
            total++;
            if (mosi_cap[0] !== exp_f) begin bad++; $display("FAIL wr_frame: got %07h want %07h", mosi_cap[0], exp_f); end
            total++;
            if (rises[0] != 26) begin bad++; $display("FAIL wr_rises: got %0d want 26", rises[0]); end
            total++;
            if (sslow[0] != 54 * 4) begin bad++; $display("FAIL wr_ss_low: got %0d want %0d", sslow[0], 54 * 4); end
            total++;
            if (a2r != 55 * 4) begin bad++; $display("FAIL wr_accept_to_ready: got %0d want %0d", a2r, 55 * 4); end
            total++;
            if (rv_cnt[0] != 0 || m_rdata[0] !== prev_rd[0]) begin
                bad++; $display("FAIL wr_no_rvalid: got cnt=%0d rdata=%0h want cnt=0 rdata=%0h", rv_cnt[0], m_rdata[0], prev_rd[0]);
            end
        end
    endtask

    task automatic test_read();
        logic [8:0]  a;
        logic [15:0] sv;
        logic [25:0] exp_f;
        int          a2r;
        bit          tmo;
        for (int i = 0; i < 4; i++) begin
            a  = (i == 0) ? 9'h010 : 9'($urandom);
            sv = (i == 0) ? 16'h5A3C : 16'($urandom);
            exp_f = {a, 1'b0, 16'h0000};
            do_cmd(0, a, 1'b0, 16'($urandom), sv, a2r, tmo);
            total++;
            if (tmo) begin bad++; $display("FAIL rd_timeout: got timeout want ready"); end
            total++;
            if (mosi_cap[0] !== exp_f) begin bad++; $display("FAIL rd_frame: got %07h want %07h", mosi_cap[0], exp_f); end
            total++;
            if (m_rdata[0] !== sv) begin bad++; $display("FAIL rd_data: got %04h want %04h", m_rdata[0], sv); end
            total++;
            if (rv_cnt[0] != 1) begin bad++; $display("FAIL rd_rvalid_count: got %0d want 1", rv_cnt[0]); end
            total++;
            if (rv_delay[0] != 54 * 4) begin bad++; $display("FAIL rd_rvalid_time: got %0d want %0d", rv_delay[0], 54 * 4); end
            prev_rd[0] = sv;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  ca [3];
        logic        cw [3];
        logic [15:0] cd [3];
        logic [15:0] cs [3];
        logic [25:0] exp_f;
        int          w;
        int          gp;
        for (int i = 0; i < 3; i++) begin
            ca[i] = 9'($urandom); cw[i] = (i == 1) ? 1'b0 : 1'($urandom);
            cd[i] = 16'($urandom); cs[i] = 16'($urandom);
        end
        @(negedge clk);
        s_addr[0] = ca[0]; s_we[0] = cw[0]; s_wdata[0] = cd[0]; sens[0] = cs[0]; s_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (s_ready[0] !== 1'b1 && w < 300) begin @(negedge clk); w++; end
            total++;
            if (s_ready[0] !== 1'b1) begin bad++; $display("FAIL b2b_timeout: got busy want ready"); break; end
            if (i > 0) begin
                exp_f = {ca[i-1], cw[i-1], (cw[i-1] ? cd[i-1] : 16'h0000)};
                total++;
                if (mosi_cap[0] !== exp_f) begin bad++; $display("FAIL b2b_frame%0d: got %07h want %07h", i - 1, mosi_cap[0], exp_f); end
                total++;
                if (rv_cnt[0] != (cw[i-1] ? 0 : 1)) begin bad++; $display("FAIL b2b_rvalid%0d: got %0d want %0d", i - 1, rv_cnt[0], cw[i-1] ? 0 : 1); end
                if (!cw[i-1]) prev_rd[0] = cs[i-1];
                total++;
                if (m_rdata[0] !== prev_rd[0]) begin bad++; $display("FAIL b2b_rdata%0d: got %04h want %04h", i - 1, m_rdata[0], prev_rd[0]); end
            end
            if (i == 3) break;
            sens[0] = cs[i];
            @(posedge clk); #1;
            total++;
            if (s_ready[0] !== 1'b0 || spi_ss_n[0] !== 1'b0) begin
                bad++; $display("FAIL b2b_start%0d: got ready=%b ss_n=%b want 0 0", i, s_ready[0], spi_ss_n[0]);
            end
            if (i > 0) begin
                gp = cyc - rise_cyc[0];
                total++;
                if (gp < 4 || gp > 5) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 4..5", i, gp); end
            end
            if (i < 2) begin
                s_addr[0] = ca[i+1]; s_we[0] = cw[i+1]; s_wdata[0] = cd[i+1];
            end else begin
                s_valid[0] = 1'b0; s_wdata[0] = 16'($urandom); s_addr[0] = 9'($urandom);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [8:0]  a;
        logic [15:0] sv;
        int          w;
        int          a2r;
        bit          tmo;
        a = 9'($urandom); sv = 16'($urandom);
        @(negedge clk);
        s_addr[0] = a; s_we[0] = 1'b0; s_wdata[0] = '0; sens[0] = sv; s_valid[0] = 1'b1;
        w = 0;
        while (s_ready[0] !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        s_valid[0] = 1'b0;
        repeat (100) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        total++;
        if (spi_ss_n[0] !== 1'b1 || spi_sck[0] !== 1'b0 || spi_mosi[0] !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs: got ss_n=%b sck=%b mosi=%b want 1 0 0", spi_ss_n[0], spi_sck[0], spi_mosi[0]);
        end
        total++;
        if (s_ready[0] !== 1'b1 || m_rvalid[0] !== 1'b0) begin
            bad++; $display("FAIL rstmid_ready: got ready=%b rvalid=%b want 1 0", s_ready[0], m_rvalid[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N; k++) prev_rd[k] = 16'h0;
        repeat (300) @(negedge clk);
        total++;
        if (rv_cnt[0] != 0 || m_rdata[0] !== 16'h0) begin
            bad++; $display("FAIL rstmid_no_rvalid: got cnt=%0d rdata=%04h want 0 0000", rv_cnt[0], m_rdata[0]);
        end
        do_cmd(0, a, 1'b0, 16'h0, sv, a2r, tmo);
        total++;
        if (tmo || m_rdata[0] !== sv || rv_cnt[0] != 1) begin
            bad++; $display("FAIL rstmid_next_read: got tmo=%0b rdata=%04h cnt=%0d want 0 %04h 1", tmo, m_rdata[0], rv_cnt[0], sv);
        end
        total++;
        if (mosi_cap[0] !== {a, 1'b0, 16'h0000} || a2r != 55 * 4) begin
            bad++; $display("FAIL rstmid_next_frame: got %07h/%0d want %07h/%0d", mosi_cap[0], a2r, {a, 1'b0, 16'h0000}, 55 * 4);
        end
        prev_rd[0] = sv;
    endtask

    task automatic test_clk_div_extremes();
        logic [8:0]  a;
        logic [15:0] wd;
        logic [15:0] sv;
        logic        we;
        logic [25:0] exp_f;
        int          a2r;
        bit          tmo;
        for (int k = 1; k < N; k++) begin
            for (int j = 0; j < 2; j++) begin
                we = (j == 0);
                a = 9'($urandom); wd = 16'($urandom); sv = 16'($urandom);
                exp_f = {a, we, (we ? wd : 16'h0000)};
                do_cmd(k, a, we, wd, sv, a2r, tmo);
                if (!we) prev_rd[k] = sv;
                total++;
                if (tmo) begin bad++; $display("FAIL div%0d_timeout: got timeout want ready", divk(k)); end
                total++;
                if (phase_err[k] != 0 || rises[k] != 26) begin
                    bad++; $display("FAIL div%0d_phases: got err=%0d rises=%0d want 0 26", divk(k), phase_err[k], rises[k]);
                end
                total++;
                if (mosi_cap[k] !== exp_f) begin bad++; $display("FAIL div%0d_frame: got %07h want %07h", divk(k), mosi_cap[k], exp_f); end
                total++;
                if (m_rdata[k] !== prev_rd[k] || rv_cnt[k] != (we ? 0 : 1)) begin
                    bad++; $display("FAIL div%0d_rdata: got %04h cnt=%0d want %04h cnt=%0d", divk(k), m_rdata[k], rv_cnt[k], prev_rd[k], we ? 0 : 1);
                end
                total++;
                if (sslow[k] != 54 * divk(k) || a2r != 55 * divk(k)) begin
                    bad++; $display("FAIL div%0d_timing: got ss=%0d a2r=%0d want %0d %0d", divk(k), sslow[k], a2r, 54 * divk(k), 55 * divk(k));
                end
            end
        end
    endtask

    task automatic test_phase_div4();
        total++;
        if (phase_err[0] != 0) begin bad++; $display("FAIL div4_phases: got %0d want 0", phase_err[0]); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_phase_div4();
        test_read();
        test_back_to_back();
        test_reset_midframe();
        test_clk_div_extremes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
